// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and other UART clients.
//   ByteW     : width of one UART data byte
//   state_e   : arbiter grant state (idle / sending a message)
//   cnt_width : width of a saturating counter that must reach 'limit'
package uart_tx_arbiter_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  // A zero limit still needs a 1-bit counter so the register is never zero-width.
  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin first-set-bit finder.
//   req   : request vector, one bit per requester
//   start : index where the scan begins (wraps past N-1 back to 0)
//   index : first requesting index at or after start
//   found : at least one request bit is set
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] start,
  output logic [IdxW-1:0] index,
  output logic            found
);

  always_comb begin
    int unsigned j;
    j     = 0;
    index = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(start) + k) % N;
      if (!found && req[j[IdxW-1:0]]) begin
        found = 1'b1;
        index = j[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter among Ports requesters.
// A requester keeps the grant until it transfers a byte flagged LAST, or until it leaves
// VALID low mid-message for Timeout consecutive cycles (Timeout = 0 disables that release).
//   CLK, RST          : clock and synchronous active-high reset
//   VALID/DATA/LAST   : per-requester byte offer (DATA slice i is bits [8i+7:8i])
//   ACK               : one-cycle accept, only ever to the current owner
//   UDIN/UOE/URDY     : UART transmit handshake; a byte moves when UOE & URDY
//   BUSY              : a grant is held
//   OWNER             : current or most recent owner index
//   TOUT              : one-cycle pulse in the first idle cycle after a forced release
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned Ports   = 4,
  parameter int unsigned Timeout = 1024,
  localparam int unsigned IdxW   = $clog2(Ports)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [Ports-1:0]       VALID,
  input  logic [ByteW*Ports-1:0] DATA,
  input  logic [Ports-1:0]       LAST,
  output logic [Ports-1:0]       ACK,
  output logic [ByteW-1:0]       UDIN,
  output logic                   UOE,
  input  logic                   URDY,
  output logic                   BUSY,
  output logic [IdxW-1:0]        OWNER,
  output logic                   TOUT
);

  localparam int unsigned     CntW    = cnt_width(Timeout);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, owner_q, owner_next, pick_idx;
  logic              pick_found;
  logic [CntW-1:0]   cnt_q;
  logic              tout_q;
  logic              in_send, own_valid, own_last, xfer, stall, expire;
  logic [ByteW-1:0]  own_data;

  uart_tx_arbiter_rr_pick #(
    .N    (Ports),
    .IdxW (IdxW)
  ) u_pick (
    .req   (VALID),
    .start (ptr_q),
    .index (pick_idx),
    .found (pick_found)
  );

  // Owner's request lines, selected by the registered owner index.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < Ports; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_valid = VALID[i];
        own_last  = LAST[i];
        own_data  = DATA[ByteW*i +: ByteW];
      end
    end
  end

  assign in_send    = (state_q == StSend);
  assign xfer       = in_send && own_valid && URDY;
  // Only an absent byte counts as a stall; UART backpressure never does.
  assign stall      = in_send && !own_valid;
  assign expire     = (Timeout != 0) && stall && (cnt_q == CntLast);
  assign owner_next = (owner_q == IdxW'(Ports - 1)) ? '0 : owner_q + 1'b1;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pick_found) state_d = StSend;
      StSend: if ((xfer && own_last) || expire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pointer, owner, stall counter and timeout pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= expire;
      if (state_q == StIdle && pick_found) begin
        owner_q <= pick_idx;
        cnt_q   <= '0;
      end
      if (xfer) begin
        cnt_q <= '0;
        if (own_last) ptr_q <= owner_next;
      end else if (stall && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (expire) ptr_q <= owner_next;
    end
  end

  // Outputs; gated by RST so a reset cycle can never accept a byte.
  always_comb begin
    ACK  = '0;
    UDIN = '0;
    UOE  = 1'b0;
    BUSY = 1'b0;
    if (in_send && !RST) begin
      BUSY = 1'b1;
      UOE  = own_valid;
      UDIN = own_data;
      for (int unsigned i = 0; i < Ports; i++) begin
        ACK[i] = (owner_q == IdxW'(i)) && own_valid && URDY;
      end
    end
  end

  assign OWNER = owner_q;
  assign TOUT  = tout_q;

endmodule
